// File: rtl/data_mem_ctrl.sv
// Handshaked MIPS MEM-stage data memory: configurable depth and latency, byte/half/word
// accesses with sign/zero extension and alignment faults. Optional macro: DMEM_BOUNDS_CHECK_EN.
module data_mem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic                w_enter_resp;
  logic [3:0]          r_cnt;
  logic                r_write;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [DEPTH];
  logic [31:0]         r_rsp_rdata;
  logic                r_rsp_fault;

  logic                w_accept;
  logic                w_a_write;
  logic [1:0]          w_a_size;
  logic                w_a_unsigned;
  logic [31:0]         w_a_addr;
  logic [31:0]         w_a_wdata;
  logic [ADDR_W-1:0]   w_idx;
  logic [1:0]          w_lane;
  logic [31:0]         w_word;
  logic [31:0]         w_byte_sh;
  logic [31:0]         w_half_sh;
  logic [31:0]         w_load;
  logic [31:0]         w_wdata_rep;
  logic [3:0]          w_be;
  logic                w_fault;
  logic                w_mem_we;

  assign w_accept  = (r_state == S_IDLE) && req_valid;
  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            w_state_next = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
    end else if (w_accept) begin
      r_cnt      <= CNT_INIT;
      r_write    <= req_write;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // With zero wait cycles the access happens on the accepting edge, before the latches load.
  assign w_a_write    = (r_state == S_IDLE) ? req_write    : r_write;
  assign w_a_size     = (r_state == S_IDLE) ? req_size     : r_size;
  assign w_a_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;
  assign w_a_addr     = (r_state == S_IDLE) ? req_addr     : r_addr;
  assign w_a_wdata    = (r_state == S_IDLE) ? req_wdata    : r_wdata;

  assign w_idx     = w_a_addr[ADDR_W+1:2];
  assign w_lane    = w_a_addr[1:0];
  assign w_word    = r_mem[w_idx];
  assign w_byte_sh = w_word >> {w_lane, 3'b000};
  assign w_half_sh = w_word >> {w_lane[1], 4'b0000};

  always_comb begin
    w_fault = 1'b0;
    case (w_a_size)
      2'b00:   w_fault = 1'b0;
      2'b01:   w_fault = w_a_addr[0];
      2'b10:   w_fault = |w_a_addr[1:0];
      default: w_fault = 1'b1;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    if (|w_a_addr[31:ADDR_W+2]) w_fault = 1'b1;
`endif
  end

`ifndef DMEM_BOUNDS_CHECK_EN
  logic w_unused_addr_hi;
  assign w_unused_addr_hi = ^w_a_addr[31:ADDR_W+2];
`endif

  always_comb begin
    w_load      = w_word;
    w_be        = 4'b0000;
    w_wdata_rep = w_a_wdata;
    case (w_a_size)
      2'b00: begin
        w_load      = {{24{~w_a_unsigned & w_byte_sh[7]}}, w_byte_sh[7:0]};
        w_be        = 4'b0001 << w_lane;
        w_wdata_rep = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_load      = {{16{~w_a_unsigned & w_half_sh[15]}}, w_half_sh[15:0]};
        w_be        = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{w_a_wdata[15:0]}};
      end
      2'b10: begin
        w_load = w_word;
        w_be   = 4'b1111;
      end
      default: begin
        w_load = 32'd0;
        w_be   = 4'b0000;
      end
    endcase
  end

  // rst_n gate keeps a request seen while reset is held from writing on a zero-wait build.
  assign w_mem_we = w_enter_resp && rst_n && w_a_write && !w_fault;

  // NOTE: the array has no reset: contents are undefined at power-up and a reset would block RAM inference.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_mem_we && w_be[n]) r_mem[w_idx][8*n +: 8] <= w_wdata_rep[8*n +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_fault <= 1'b0;
    end else if (w_enter_resp) begin
      r_rsp_fault <= w_fault;
      r_rsp_rdata <= (w_fault || w_a_write) ? 32'd0 : w_load;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: instance A (ADDR_W=8, WAIT_CYCLES=1) and instance B
// (ADDR_W=4, WAIT_CYCLES=0) for aliasing; expected responses go through a scoreboard queue.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;

  logic        ready_a, rsp_valid_a, rsp_fault_a;
  logic [31:0] rdata_a;
  logic        ready_b, rsp_valid_b, rsp_fault_b;
  logic [31:0] rdata_b;

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid_a), .req_ready(ready_a),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_fault(rsp_fault_a)
  );

  data_mem_ctrl #(.ADDR_W(4), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid_b), .req_ready(ready_b),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b), .rsp_fault(rsp_fault_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance A (sel_b=0) or B (sel_b=1); checks handshake timing and response.
  task automatic access(input bit sel_b, input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_flt);
    int   lat     = sel_b ? 1 : 2;
    int   wait_n  = 0;
    int   first_k = -1;
    int   vcnt    = 0;
    int   rlow    = 0;
    logic rdy;
    logic vld;
    exp_t e;
    @(negedge clk);
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (sel_b) valid_b = 1'b1;
    else       valid_a = 1'b1;
    rdy = sel_b ? ready_b : ready_a;
    while (!rdy && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
      rdy = sel_b ? ready_b : ready_a;
    end
    check($sformatf("%s/ready_before_accept", tag), {31'd0, rdy}, 32'd1);
    sb_q.push_back('{rdata: exp_rd, fault: exp_flt});
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      rdy = sel_b ? ready_b : ready_a;
      vld = sel_b ? rsp_valid_b : rsp_valid_a;
      if (k <= lat && !rdy) rlow++;
      if (vld) begin
        vcnt++;
        if (first_k < 0) begin
          first_k = k;
          e = sb_q.pop_front();
          check($sformatf("%s/rdata", tag), sel_b ? rdata_b : rdata_a, e.rdata);
          check($sformatf("%s/fault", tag), {31'd0, sel_b ? rsp_fault_b : rsp_fault_a},
                {31'd0, e.fault});
        end
      end
    end
    if (first_k < 0) e = sb_q.pop_front();
    check($sformatf("%s/latency", tag), 32'(first_k), 32'(lat));
    check($sformatf("%s/pulse_cycles", tag), 32'(vcnt), 32'd1);
    check($sformatf("%s/ready_low_cycles", tag), 32'(rlow), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   vseen;
    logic exp_alias_flt;
    logic [31:0] exp_alias_rd;

    // Reset values on both instances.
    repeat (3) @(negedge clk);
    check("rst/ready_a", {31'd0, ready_a}, 32'd1);
    check("rst/valid_a", {31'd0, rsp_valid_a}, 32'd0);
    check("rst/rdata_a", rdata_a, 32'd0);
    check("rst/fault_a", {31'd0, rsp_fault_a}, 32'd0);
    check("rst/ready_b", {31'd0, ready_b}, 32'd1);
    check("rst/valid_b", {31'd0, rsp_valid_b}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store and load.
    access(0, "st_w_10", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    access(0, "ld_w_10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access(0, "ld_w_10_uns", 0, 2'b10, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0);

    // Byte loads with extension.
    access(0, "ld_b_13_s", 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFFDE, 0);
    access(0, "ld_b_13_u", 0, 2'b00, 1, 32'h13, 32'h0, 32'h000000DE, 0);
    access(0, "ld_b_10_s", 0, 2'b00, 0, 32'h10, 32'h0, 32'hFFFFFFEF, 0);
    access(0, "ld_b_11_u", 0, 2'b00, 1, 32'h11, 32'h0, 32'h000000BE, 0);

    // Half store preserves the other lanes.
    access(0, "st_h_12", 1, 2'b01, 0, 32'h12, 32'hFFFF1234, 32'h0, 0);
    access(0, "ld_w_after_h", 0, 2'b10, 0, 32'h10, 32'h0, 32'h1234BEEF, 0);
    access(0, "ld_h_10_s", 0, 2'b01, 0, 32'h10, 32'h0, 32'hFFFFBEEF, 0);
    access(0, "ld_h_10_u", 0, 2'b01, 1, 32'h10, 32'h0, 32'h0000BEEF, 0);
    access(0, "ld_h_12_s", 0, 2'b01, 0, 32'h12, 32'h0, 32'h00001234, 0);

    // Byte store into lane 1.
    access(0, "st_b_11", 1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0);
    access(0, "ld_w_after_b", 0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0);

    // Misaligned and illegal accesses.
    access(0, "st_w_11_fault", 1, 2'b10, 0, 32'h11, 32'h55555555, 32'h0, 1);
    access(0, "ld_w_after_fault", 0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0);
    access(0, "ld_h_13_fault", 0, 2'b01, 0, 32'h13, 32'h0, 32'h0, 1);
    access(0, "ld_sz3_fault", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1);
    access(0, "st_h_11_fault", 1, 2'b01, 0, 32'h11, 32'h00007777, 32'h0, 1);
    access(0, "ld_w_after_fault2", 0, 2'b10, 0, 32'h10, 32'h0, 32'h123455EF, 0);

    // Reset during WAIT discards the pending store.
    access(0, "st_w_20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0, 0);
    @(negedge clk);
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 32'h20;
    req_wdata = 32'hCAFEF00D;
    valid_a   = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    @(negedge clk);
    check("midrst/in_wait_ready", {31'd0, ready_a}, 32'd0);
    rst_n = 1'b0;
    vseen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid_a) vseen++;
    end
    check("midrst/ready_in_reset", {31'd0, ready_a}, 32'd1);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid_a) vseen++;
    end
    check("midrst/no_rsp", 32'(vseen), 32'd0);
    access(0, "ld_w_20_after_rst", 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344, 0);

    // Aliasing on the 16-word, zero-wait instance.
`ifdef DMEM_BOUNDS_CHECK_EN
    exp_alias_flt = 1'b1;
    exp_alias_rd  = 32'hA5A5A5A5;
`else
    exp_alias_flt = 1'b0;
    exp_alias_rd  = 32'h0BADF00D;
`endif
    access(1, "b_st_w_04", 1, 2'b10, 0, 32'h04, 32'hA5A5A5A5, 32'h0, 0);
    access(1, "b_ld_w_04", 0, 2'b10, 0, 32'h04, 32'h0, 32'hA5A5A5A5, 0);
    access(1, "b_st_w_44", 1, 2'b10, 0, 32'h44, 32'h0BADF00D, 32'h0, exp_alias_flt);
    access(1, "b_ld_w_04_alias", 0, 2'b10, 0, 32'h04, 32'h0, exp_alias_rd, 0);
    access(1, "b_ld_b_07_s", 0, 2'b00, 0, 32'h07, 32'h0, {{24{exp_alias_rd[31]}}, exp_alias_rd[31:24]}, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, handshaked data memory for the MIPS MEM stage. It replaces the fixed 16-word, word-only memory. It adds configurable depth and access latency, byte/half/word accesses with sign/zero extension, and misalignment fault reporting. Requests enter through a valid/ready handshake. Each response is a single-cycle pulse.

Parameters:
ADDR_W, 8, word-address width; memory depth = 2^ADDR_W 32-bit words
WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
req_addr  in  32  byte address (ALU result)
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  extended load data; 0 for stores and faults
rsp_fault  out  1  access rejected; valid only with rsp_valid

Behaviour:
- Reset is asynchronous:
  - FSM goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - Memory array contents are not reset; after power-up they are undefined.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, size, unsigned, addr and wdata.
  - Go to WAIT and load the counter with WAIT_CYCLES-1. If WAIT_CYCLES=0, go directly to RESP.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle.
  - When the counter is 0, go to RESP.
- Memory access and commit:
  - The access is performed on the clock edge that enters RESP.
  - Stores commit on that edge.
  - rsp_rdata and rsp_fault are registered on that same edge.
- RESP:
  - rsp_valid=1 and req_ready=0 for exactly one cycle, then return to IDLE.
  - There is no response back-pressure.
- Latency and throughput:
  - Acceptance to rsp_valid is WAIT_CYCLES+1 cycles.
  - Back-to-back throughput is one request per WAIT_CYCLES+2 cycles.
- Addressing:
  - Word index = req_addr[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses alias modulo depth.
  - Byte lanes are little-endian: lane n = bits [8n+7:8n].
- Alignment faults:
  - half with addr[0]=1 is a fault.
  - word with addr[1:0]!=00 is a fault.
  - size 11 is a fault.
  - On a fault: no memory write, rsp_fault=1, rsp_rdata=0.
- Stores:
  - byte writes lane addr[1:0].
  - half writes lanes {addr[1],0} and {addr[1],1}.
  - word writes all lanes.
  - Unselected lanes are preserved.
  - rsp_rdata=0.
- Loads:
  - Select the lane(s) as for stores, right-align them, then sign- or zero-extend to 32 bits.
  - req_unsigned is ignored for word loads.
- rsp_rdata and rsp_fault hold their values between responses. They are meaningful only while rsp_valid=1.
- Reset mid-operation (in WAIT): the pending request is discarded and its store never commits.
- A request asserted while req_ready=0 is neither latched nor acknowledged. The master must hold it until req_ready=1.

Optional Feature:
Macro: DMEM_BOUNDS_CHECK_EN.
- Defined: any nonzero req_addr[31:ADDR_W+2] is a fault. No write is performed, rsp_fault=1 and rsp_rdata=0. This check is evaluated in addition to the alignment check.
- Undefined: upper address bits are ignored and addresses alias.

Test Plan:
- Reset, then word store 0xDEADBEEF at 0x10, then word load at 0x10 (WAIT_CYCLES=1):
  - rsp_valid exactly 2 cycles after each acceptance.
  - rsp_fault=0 for both accesses.
  - Load returns 0xDEADBEEF.
  - req_ready=0 for 2 cycles after each acceptance.
- Byte loads from 0x10 containing 0xDEADBEEF:
  - addr 0x13 signed → 0xFFFFFFDE.
  - addr 0x13 unsigned → 0x000000DE.
  - addr 0x10 signed → 0xFFFFFFEF.
- Half store 0x1234 to 0x12 over 0xDEADBEEF, then word load at 0x10:
  - Load returns 0x1234BEEF, proving lanes 0/1 are preserved.
  - Half load at 0x10, signed → 0xFFFFBEEF.
- Misaligned accesses:
  - Word store to 0x11 → rsp_fault=1, rsp_rdata=0; a following word load at 0x10 is unchanged.
  - Half load at 0x13 → fault.
  - size 11 → fault.
- Reset mid-operation: assert rst_n=0 during WAIT of a store of 0xCAFEF00D to 0x20:
  - rsp_valid is never asserted for that request.
  - After reset, a load at 0x20 returns the old value.
- Aliasing with ADDR_W=4:
  - Store to 0x44 then load from 0x04 → same data.
  - With DMEM_BOUNDS_CHECK_EN, the store to 0x44 faults and 0x04 is unchanged.
